// File: rtl/column_ram_sched.sv
// -----------------------------------------------------------------------------
// column_ram_sched
// Sequencer for the 85-lane column message RAM of the layered decoder. For each
// layer it streams the layer's read addresses, then writes back the updated
// messages returned by the node units. It steps through every layer of every
// iteration and pulses done when decoding is complete.
//
// Optional feature macro: COLUMN_RAM_SCHED_EARLY_TERM_EN
//   defined   : early_term is sampled in LAYER_END of the last layer. When it
//               is high, decoding finishes after that iteration.
//   undefined : early_term is ignored. ITER_MAX iterations always run.
//
// Ports
//   sys_clk    in   system clock
//   rst        in   synchronous active-high reset
//   start      in   one-cycle pulse that begins decoding (accepted in IDLE only)
//   busy       out  high from the accepted start until done
//   done       out  one-cycle pulse at the end of decoding
//   sync_addr  out  RAM address (registered)
//   we         out  RAM write enable (registered)
//   wr_data    out  RAM write data broadcast to all lanes (registered)
//   rd_valid   out  RAM read data valid at the Dout lanes
//   rd_idx     out  word index of the data flagged by rd_valid
//   wb_valid   in   write-back beat valid
//   wb_data    in   write-back message
//   wb_ready   out  write-back beat accepted (high in WR only)
//   layer_id   out  current layer
//   iter_cnt   out  completed iterations
//   early_term in   syndrome-pass indication
//
// LAYER_DEPTH and LAYER_NUM are expected to be >= 2 so that their index
// fields are at least one bit wide.
// -----------------------------------------------------------------------------
module column_ram_sched #(
   parameter int QUAN_SIZE   = 4,
   parameter int DEPTH       = 1024,
   parameter int ADDR        = $clog2(DEPTH),
   parameter int LAYER_NUM   = 4,
   parameter int LAYER_DEPTH = 8,
   parameter int ITER_MAX    = 10,
   parameter int RD_LAT      = 2
) (
   input  logic                             sys_clk,
   input  logic                             rst,
   input  logic                             start,
   output logic                             busy,
   output logic                             done,
   output logic [ADDR-1:0]                  sync_addr,
   output logic                             we,
   output logic [QUAN_SIZE-1:0]             wr_data,
   output logic                             rd_valid,
   output logic [$clog2(LAYER_DEPTH)-1:0]   rd_idx,
   input  logic                             wb_valid,
   input  logic [QUAN_SIZE-1:0]             wb_data,
   output logic                             wb_ready,
   output logic [$clog2(LAYER_NUM)-1:0]     layer_id,
   output logic [$clog2(ITER_MAX+1)-1:0]    iter_cnt,
   input  logic                             early_term
);

   localparam int IDX_W   = $clog2(LAYER_DEPTH);
   localparam int LAYER_W = $clog2(LAYER_NUM);
   localparam int ITER_W  = $clog2(ITER_MAX+1);

   localparam logic [IDX_W-1:0]   CNT_LAST   = IDX_W'(LAYER_DEPTH - 1);
   localparam logic [LAYER_W-1:0] LAYER_LAST = LAYER_W'(LAYER_NUM - 1);
   localparam logic [ITER_W-1:0]  ITER_END   = ITER_W'(ITER_MAX);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RD        = 3'd1,
      ST_WR        = 3'd2,
      ST_LAYER_END = 3'd3,
      ST_FINISH    = 3'd4
   } state_t;

   state_t               state_r, state_s;
   logic [IDX_W-1:0]     cnt_r, cnt_s;
   logic [ADDR-1:0]      sync_addr_s;
   logic                 we_s;
   logic [QUAN_SIZE-1:0] wr_data_s;
   logic                 busy_s;
   logic                 done_s;
   logic [LAYER_W-1:0]   layer_s;
   logic [ITER_W-1:0]    iter_s;
   logic [ITER_W-1:0]    iter_inc_s;
   logic [ADDR-1:0]      base_s;
   logic [ADDR-1:0]      word_addr_s;
   logic                 et_s;

   // issue_r / issue_idx_r are aligned with the read address on sync_addr;
   // the pipeline below delays them by the RAM read latency.
   logic                 issue_r, issue_s;
   logic [IDX_W-1:0]     issue_idx_r;
   logic [RD_LAT-1:0]    vld_pipe_r;
   logic [IDX_W-1:0]     idx_pipe_r [RD_LAT];

`ifdef COLUMN_RAM_SCHED_EARLY_TERM_EN
   assign et_s = early_term;
`else
   logic unused_early_term;
   assign unused_early_term = early_term;
   assign et_s = 1'b0;
`endif

   assign base_s      = ADDR'(layer_id) * ADDR'(LAYER_DEPTH);
   assign word_addr_s = base_s + ADDR'(cnt_r);
   assign iter_inc_s  = iter_cnt + ITER_W'(1);

   // Next-state and next-output decode for the sequencer.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      sync_addr_s = sync_addr;
      we_s        = 1'b0;
      wr_data_s   = wr_data;
      busy_s      = busy;
      done_s      = 1'b0;
      layer_s     = layer_id;
      iter_s      = iter_cnt;
      issue_s     = 1'b0;
      wb_ready    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s = ST_RD;
               busy_s  = 1'b1;
               layer_s = {LAYER_W{1'b0}};
               iter_s  = {ITER_W{1'b0}};
               cnt_s   = {IDX_W{1'b0}};
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RD: begin
            sync_addr_s = word_addr_s;
            issue_s     = 1'b1;
            if (cnt_r == CNT_LAST) begin
               cnt_s   = {IDX_W{1'b0}};
               state_s = ST_WR;
            end else begin
               cnt_s   = cnt_r + IDX_W'(1);
            end
         end
         ST_WR: begin
            wb_ready = 1'b1;
            if (wb_valid) begin
               sync_addr_s = word_addr_s;
               we_s        = 1'b1;
               wr_data_s   = wb_data;
               if (cnt_r == CNT_LAST) begin
                  cnt_s   = {IDX_W{1'b0}};
                  state_s = ST_LAYER_END;
               end else begin
                  cnt_s   = cnt_r + IDX_W'(1);
               end
            end else begin
               state_s = ST_WR;
            end
         end
         ST_LAYER_END: begin
            if (layer_id != LAYER_LAST) begin
               layer_s = layer_id + LAYER_W'(1);
               state_s = ST_RD;
            end else begin
               layer_s = {LAYER_W{1'b0}};
               iter_s  = iter_inc_s;
               // done/busy are registered, so they change on entry to FINISH.
               if ((iter_inc_s == ITER_END) || et_s) begin
                  state_s = ST_FINISH;
                  done_s  = 1'b1;
                  busy_s  = 1'b0;
               end else begin
                  state_s = ST_RD;
               end
            end
         end
         ST_FINISH: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
            busy_s  = 1'b0;
         end
      endcase
   end

   // State and registered RAM control outputs.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         cnt_r       <= {IDX_W{1'b0}};
         sync_addr   <= {ADDR{1'b0}};
         we          <= 1'b0;
         wr_data     <= {QUAN_SIZE{1'b0}};
         busy        <= 1'b0;
         done        <= 1'b0;
         layer_id    <= {LAYER_W{1'b0}};
         iter_cnt    <= {ITER_W{1'b0}};
         issue_r     <= 1'b0;
         issue_idx_r <= {IDX_W{1'b0}};
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         sync_addr   <= sync_addr_s;
         we          <= we_s;
         wr_data     <= wr_data_s;
         busy        <= busy_s;
         done        <= done_s;
         layer_id    <= layer_s;
         iter_cnt    <= iter_s;
         issue_r     <= issue_s;
         issue_idx_r <= cnt_r;
      end
   end

   // Read-valid pipeline matching the RAM read latency.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         vld_pipe_r <= {RD_LAT{1'b0}};
         for (int i = 0; i < RD_LAT; i++) begin
            idx_pipe_r[i] <= {IDX_W{1'b0}};
         end
      end else begin
         vld_pipe_r[0] <= issue_r;
         idx_pipe_r[0] <= issue_idx_r;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe_r[i] <= vld_pipe_r[i-1];
            idx_pipe_r[i] <= idx_pipe_r[i-1];
         end
      end
   end

   assign rd_valid = vld_pipe_r[RD_LAT-1];
   assign rd_idx   = idx_pipe_r[RD_LAT-1];

endmodule

// File: tb/tb_column_ram_sched.sv
// -----------------------------------------------------------------------------
// tb_column_ram_sched
// Scoreboard bench for column_ram_sched with LAYER_NUM=2, LAYER_DEPTH=4,
// ITER_MAX=2, RD_LAT=2. The stimulus process pushes expected reads, writes and
// done results into queues; a monitor pops and compares whenever the DUT
// presents rd_valid, we or done.
// -----------------------------------------------------------------------------
module tb_column_ram_sched;

   localparam int QS = 4;
   localparam int DEPTH = 1024;
   localparam int AW = 10;
   localparam int LN = 2;
   localparam int LD = 4;
   localparam int IM = 2;
   localparam int RL = 2;

   logic          sys_clk = 1'b0;
   logic          rst, start, wb_valid, early_term;
   logic [QS-1:0] wb_data;
   logic          busy, done, we, rd_valid, wb_ready;
   logic [AW-1:0] sync_addr;
   logic [QS-1:0] wr_data;
   logic [1:0]    rd_idx;
   logic [0:0]    layer_id;
   logic [1:0]    iter_cnt;

   column_ram_sched #(
      .QUAN_SIZE(QS), .DEPTH(DEPTH), .LAYER_NUM(LN), .LAYER_DEPTH(LD),
      .ITER_MAX(IM), .RD_LAT(RL)
   ) dut (
      .sys_clk(sys_clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .sync_addr(sync_addr), .we(we), .wr_data(wr_data), .rd_valid(rd_valid),
      .rd_idx(rd_idx), .wb_valid(wb_valid), .wb_data(wb_data),
      .wb_ready(wb_ready), .layer_id(layer_id), .iter_cnt(iter_cnt),
      .early_term(early_term)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [QS-1:0] val;
   } ent_t;

   ent_t rq[$];
   ent_t wq[$];
   int   dq[$];

   int n_cmp = 0;
   int n_err = 0;
   int done_cnt = 0;
   int beat_k = 0;
   bit chk_en = 1'b0;
   bit pat_mode = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [QS-1:0] beat_val(input int k);
      return QS'((k * 5 + 3) % 16);
   endfunction

   // Write-back driver: presents beat values in order, advancing on acceptance.
   initial begin
      bit pat[6];
      int pidx;
      bit prev_v;
      bit prev_r;
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1;
      pat[3] = 1'b1; pat[4] = 1'b0; pat[5] = 1'b1;
      pidx = 0;
      prev_v = 1'b0;
      prev_r = 1'b0;
      wb_valid = 1'b0;
      wb_data = 4'd0;
      forever begin
         @(posedge sys_clk);
         #1;
         if (prev_v && prev_r) beat_k++;
         if (pat_mode && wb_ready) begin
            wb_valid = pat[pidx];
            pidx = (pidx == 5) ? 0 : pidx + 1;
         end else begin
            wb_valid = 1'b1;
         end
         wb_data = beat_val(beat_k);
         prev_v = wb_valid;
         prev_r = wb_ready;
      end
   end

   // Monitor: compares DUT outputs against the scoreboard queues.
   bit            acc_prev = 1'b0;
   logic          h1_we = 1'b0, h2_we = 1'b0;
   logic [AW-1:0] h1_addr = '0, h2_addr = '0;
   always @(negedge sys_clk) begin
      if (!chk_en) begin
         acc_prev = 1'b0;
         h1_we = 1'b0; h2_we = 1'b0;
         h1_addr = '0; h2_addr = '0;
      end else begin
         ent_t e;
         check("we_follows_beat", we, acc_prev);
         if (we) begin
            if (wq.size() == 0) begin
               check("unexpected_write", 0, 1);
            end else begin
               e = wq.pop_front();
               check("wr_addr", sync_addr, e.addr);
               check("wr_data", wr_data, e.val);
            end
         end
         if (rd_valid) begin
            if (rq.size() == 0) begin
               check("unexpected_read", 0, 1);
            end else begin
               e = rq.pop_front();
               check("rd_addr_2cyc_before", {h2_we, h2_addr}, {1'b0, e.addr});
               check("rd_idx", rd_idx, e.val);
            end
         end
         if (done) begin
            if (dq.size() == 0) begin
               check("unexpected_done", 0, 1);
            end else begin
               check("done_iter_cnt", iter_cnt, dq.pop_front());
               check("done_layer_id", layer_id, 0);
               check("done_busy", busy, 0);
               check("done_reads_left", rq.size(), 0);
               check("done_writes_left", wq.size(), 0);
            end
            done_cnt++;
         end
         acc_prev = wb_valid & wb_ready;
         h2_we = h1_we; h2_addr = h1_addr;
         h1_we = we;    h1_addr = sync_addr;
      end
   end

   task automatic push_expect(input int n_iter);
      ent_t e;
      int bk;
      bk = 0;
      for (int it = 0; it < n_iter; it++) begin
         for (int l = 0; l < LN; l++) begin
            for (int i = 0; i < LD; i++) begin
               e.addr = AW'(l * LD + i);
               e.val  = QS'(i);
               rq.push_back(e);
               e.val  = beat_val(bk);
               wq.push_back(e);
               bk++;
            end
         end
      end
      dq.push_back(n_iter);
   endtask

   task automatic pulse_start();
      @(posedge sys_clk); #1; start = 1'b1;
      @(posedge sys_clk); #1; start = 1'b0;
   endtask

   task automatic run(input int n_iter, input bit extra);
      int cyc;
      @(negedge sys_clk);
      push_expect(n_iter);
      beat_k = 0;
      done_cnt = 0;
      pulse_start();
      cyc = 0;
      while (done_cnt == 0 && cyc < 400) begin
         @(posedge sys_clk); #1;
         start = extra && (cyc == 5 || cyc == 20);
         cyc++;
      end
      start = 1'b0;
      check("done_seen", done_cnt > 0, 1);
      repeat (8) @(posedge sys_clk);
      #1;
      check("done_once", done_cnt, 1);
      check("idle_busy", busy, 0);
      check("idle_wb_ready", wb_ready, 0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_we"}, we, 0);
      check({tag, "_rd_valid"}, rd_valid, 0);
      check({tag, "_wb_ready"}, wb_ready, 0);
      check({tag, "_sync_addr"}, sync_addr, 0);
      check({tag, "_wr_data"}, wr_data, 0);
      check({tag, "_rd_idx"}, rd_idx, 0);
      check({tag, "_layer_id"}, layer_id, 0);
      check({tag, "_iter_cnt"}, iter_cnt, 0);
   endtask

   task automatic run_reset_mid_wr();
      int cyc;
      @(negedge sys_clk);
      push_expect(IM);
      beat_k = 0;
      done_cnt = 0;
      pulse_start();
      cyc = 0;
      while (!(layer_id == 1'b1 && wb_ready) && cyc < 200) begin
         @(posedge sys_clk); #1;
         cyc++;
      end
      check("reach_layer1_wr", (layer_id == 1'b1) && wb_ready, 1);
      repeat (2) @(posedge sys_clk);
      #1;
      chk_en = 1'b0;
      rst = 1'b1;
      @(posedge sys_clk); #1;
      rst = 1'b0;
      @(negedge sys_clk);
      check_idle_outputs("after_rst");
      for (int i = 0; i < 3; i++) begin
         @(negedge sys_clk);
         check("no_done_after_rst", done, 0);
         check("still_idle_after_rst", busy, 0);
      end
      rq.delete();
      wq.delete();
      dq.delete();
      @(posedge sys_clk); #1;
      chk_en = 1'b1;
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      early_term = 1'b0;
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      check_idle_outputs("reset");
      @(posedge sys_clk); #1;
      rst = 1'b0;
      chk_en = 1'b1;

      // Full decode with write-back always valid.
      run(IM, 1'b0);

      // Write-back valid toggling 1,0,1,1,0,1 during WR.
      pat_mode = 1'b1;
      run(IM, 1'b0);
      pat_mode = 1'b0;

      // Reset in the middle of layer 1 write-back, then restart from 0.
      run_reset_mid_wr();
      run(IM, 1'b0);

      // Extra start pulses while busy are ignored.
      run(IM, 1'b1);

      // early_term held high, including the start cycle.
      early_term = 1'b1;
`ifdef COLUMN_RAM_SCHED_EARLY_TERM_EN
      run(1, 1'b0);
`else
      run(IM, 1'b0);
`endif
      early_term = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/column_ram_sched.md
Name: column_ram_sched

Overview:
- Sequencer for the 85-lane column message RAM in the layered decoder memory subsystem.
- Drives the RAM's shared `sync_addr` / `we` / `Din` controls. Per layer it reads that layer's region, then writes back the updated messages returned by the node units.
- Steps through all layers and iterations, then signals completion to the top-level decoder controller.

Parameters:
- QUAN_SIZE, 4, message width in bits (one lane's `Din`).
- DEPTH, 1024, column RAM depth.
- ADDR, $clog2(DEPTH), address width.
- LAYER_NUM, 4, layers per decoding iteration.
- LAYER_DEPTH, 8, RAM words per layer. Constraint: LAYER_NUM*LAYER_DEPTH <= DEPTH.
- ITER_MAX, 10, maximum decoding iterations (>=1).
- RD_LAT, 2, RAM read latency in cycles (>=1).

Ports:
- sys_clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin decoding
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of decoding
- sync_addr  out  ADDR  RAM address (registered)
- we  out  1  RAM write enable (registered)
- wr_data  out  QUAN_SIZE  RAM write data, broadcast to all lanes (registered)
- rd_valid  out  1  RAM read data valid at the Dout lanes
- rd_idx  out  $clog2(LAYER_DEPTH)  word index of the data currently flagged by rd_valid
- wb_valid  in  1  write-back beat valid
- wb_data  in  QUAN_SIZE  write-back message
- wb_ready  out  1  write-back beat accepted (combinational from state)
- layer_id  out  $clog2(LAYER_NUM)  current layer
- iter_cnt  out  $clog2(ITER_MAX+1)  completed iterations
- early_term  in  1  syndrome-pass indication

Behaviour:
- Reset: state IDLE. busy, done, we, rd_valid, wb_ready = 0. sync_addr, wr_data, rd_idx, layer_id, iter_cnt = 0. rd_valid pipeline flushed.
- Reset mid-operation aborts immediately. No done pulse. Outputs at reset values on the following cycle.
- Layer base address = layer_id*LAYER_DEPTH. Word counter cnt runs 0..LAYER_DEPTH-1. No wrap beyond the layer region.
- States: IDLE, RD, WR, LAYER_END, FINISH.
- IDLE:
  - start=1 -> RD, with busy=1, layer_id=0, iter_cnt=0, cnt=0.
  - start is ignored in every other state.
- RD:
  - One address per cycle: sync_addr=base+cnt, we=0.
  - After LAYER_DEPTH issues -> WR, cnt=0.
  - rd_valid and rd_idx are a RD_LAT-stage delay of (issue, cnt): the first rd_valid appears RD_LAT cycles after the first address.
- WR:
  - wb_ready=1.
  - Each cycle with wb_valid=1 registers sync_addr=base+cnt, we=1, wr_data=wb_data on the next edge, and increments cnt.
  - Cycles with wb_valid=0 give we=0; sync_addr holds.
  - After the LAYER_DEPTH-th beat -> LAYER_END.
  - wb_ready=0 in all other states; wb_valid outside WR is ignored.
- LAYER_END (1 cycle, we=0):
  - If layer_id < LAYER_NUM-1: layer_id+1, go to RD.
  - Otherwise: layer_id=0, iter_cnt+1. If the new iter_cnt == ITER_MAX, go to FINISH; else go to RD.
- FINISH (1 cycle): done=1, busy=0, then IDLE.
  - iter_cnt and layer_id hold until the next start.
- The RD -> WR transition does not wait for rd_valid drain: write-back beats may be accepted while read data is still in flight. The node units guarantee ordering.
- start and early_term arriving on the same cycle in IDLE: start is taken, early_term is ignored.

Optional Feature:
- Macro: COLUMN_RAM_SCHED_EARLY_TERM_EN.
- Defined: early_term is sampled in LAYER_END of the last layer only. If high, go to FINISH after incrementing iter_cnt, regardless of ITER_MAX.
- Undefined: the early_term input is present but unused. Decoding always runs ITER_MAX iterations.

Test Plan:
- Parameters for all scenarios: LAYER_NUM=2, LAYER_DEPTH=4, ITER_MAX=2, RD_LAT=2.
- Single start, wb_valid held 1 -> per layer:
  - reads at addresses 0,1,2,3, then writes at 0,1,2,3; next layer reads 4..7, then writes 4..7;
  - done pulses after iter_cnt reaches 2, with 16 write beats and 16 reads total.
- Read timing -> first rd_valid exactly 2 cycles after the sync_addr=0 read issue; rd_idx sequence 0,1,2,3 with no gaps.
- wb_valid toggling 1,0,1,1,0,1 in WR:
  - we is high only on cycles following accepted beats;
  - wr_data matches wb_data in order; sync_addr = 0,1,2,3.
- Reset asserted mid-WR of layer 1:
  - next cycle busy=0, we=0, rd_valid=0, state IDLE, no done pulse;
  - a new start restarts from address 0.
- start pulsed again while busy -> ignored; exactly one done pulse.
- With COLUMN_RAM_SCHED_EARLY_TERM_EN defined, early_term=1 during the first iteration's last LAYER_END -> done after iter_cnt=1. With it undefined -> done after iter_cnt=2.
